// File: rtl/div_issue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : div_issue                                                       |
// | Purpose  : EX-stage issue/stall/capture logic for a multi-cycle divider.   |
// |            Optional macro DIV_ZERO_FLAG_EN: divisor-0 bypass + divzero_o.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module div_issue #(
  parameter int DATA_W  = 32,
  parameter int MAX_CYC = 40
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                div_req_i,
  input  logic                div_signed_i,
  input  logic [DATA_W-1:0]   reg1_i,
  input  logic [DATA_W-1:0]   reg2_i,
  input  logic                flush_i,
  input  logic                stall_i,
  output logic                div_start_o,
  output logic                div_annul_o,
  output logic                div_signed_o,
  output logic [DATA_W-1:0]   div_op1_o,
  output logic [DATA_W-1:0]   div_op2_o,
  input  logic [2*DATA_W-1:0] div_result_i,
  input  logic                div_ready_i,
  output logic                stallreq_o,
  output logic                hilo_we_o,
  output logic [DATA_W-1:0]   hi_o,
  output logic [DATA_W-1:0]   lo_o,
  output logic                divzero_o,
  output logic                err_o
);

  localparam int CNT_W = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_start;
  logic                r_signed;
  logic [DATA_W-1:0]   r_op1;
  logic [DATA_W-1:0]   r_op2;
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;
  logic                w_issue;
  logic                w_bypass;
  logic                w_capture;
  logic                w_timeout;

  always_comb begin
    w_next      = r_state;
    w_issue     = 1'b0;
    w_bypass    = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = (r_cnt == CNT_W'(MAX_CYC - 1));
    div_annul_o = 1'b0;
    err_o       = 1'b0;
    stallreq_o  = 1'b0;
    hilo_we_o   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (div_req_i && !flush_i) begin
          stallreq_o = 1'b1;
`ifdef DIV_ZERO_FLAG_EN
          w_bypass = (reg2_i == '0);
`endif
          if (w_bypass) begin
            w_next = S_DONE;
          end else begin
            w_issue = 1'b1;
            w_next  = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        stallreq_o = 1'b1;
        // Flush outranks a same-cycle ready: the result is dropped unseen.
        if (flush_i) begin
          div_annul_o = 1'b1;
          w_next      = S_IDLE;
        end else if (div_ready_i) begin
          w_capture = 1'b1;
          w_next    = S_DONE;
        end else if (w_timeout) begin
          div_annul_o = 1'b1;
          err_o       = 1'b1;
          w_next      = S_IDLE;
        end
      end
      S_DONE: begin
        hilo_we_o = !flush_i;
        if (flush_i || !stall_i) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_start  <= 1'b0;
      r_signed <= 1'b0;
      r_op1    <= '0;
      r_op2    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_state <= w_next;
      if (w_issue) begin
        r_op1    <= reg1_i;
        r_op2    <= reg2_i;
        r_signed <= div_signed_i;
        r_start  <= 1'b1;
        r_cnt    <= '0;
      end
      if (w_bypass) begin
        r_hi <= '0;
        r_lo <= '0;
      end
      if (r_state == S_BUSY) begin
        if (!w_timeout) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
        if (w_next != S_BUSY) begin
          r_start <= 1'b0;
        end
        if (w_capture) begin
          {r_hi, r_lo} <= div_result_i;
        end
        if (err_o) begin
          r_hi <= '0;
          r_lo <= '0;
        end
      end
    end
  end

`ifdef DIV_ZERO_FLAG_EN
  logic r_divzero;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_divzero <= 1'b0;
    end else if (w_bypass) begin
      r_divzero <= 1'b1;
    end else if (w_next == S_IDLE) begin
      r_divzero <= 1'b0;
    end
  end

  assign divzero_o = (r_state == S_DONE) && r_divzero;
`else
  assign divzero_o = 1'b0;
`endif

  assign div_start_o  = r_start;
  assign div_signed_o = r_signed;
  assign div_op1_o    = r_op1;
  assign div_op2_o    = r_op2;
  assign hi_o         = r_hi;
  assign lo_o         = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_div_issue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_div_issue                                                    |
// | Purpose  : Directed self-checking bench for div_issue.                     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_div_issue;

  localparam int DATA_W  = 32;
  localparam int MAX_CYC = 40;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              div_req_i = 1'b0;
  logic              div_signed_i = 1'b0;
  logic [31:0]       reg1_i = '0;
  logic [31:0]       reg2_i = '0;
  logic              flush_i = 1'b0;
  logic              stall_i = 1'b0;
  logic [63:0]       div_result_i = '0;
  logic              div_ready_i = 1'b0;
  logic              div_start_o, div_annul_o, div_signed_o;
  logic [31:0]       div_op1_o, div_op2_o, hi_o, lo_o;
  logic              stallreq_o, hilo_we_o, divzero_o, err_o;

  int total = 0;
  int bad   = 0;

  div_issue #(.DATA_W(DATA_W), .MAX_CYC(MAX_CYC)) dut (
    .clk(clk), .rst(rst),
    .div_req_i(div_req_i), .div_signed_i(div_signed_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i),
    .flush_i(flush_i), .stall_i(stall_i),
    .div_start_o(div_start_o), .div_annul_o(div_annul_o),
    .div_signed_o(div_signed_o), .div_op1_o(div_op1_o), .div_op2_o(div_op2_o),
    .div_result_i(div_result_i), .div_ready_i(div_ready_i),
    .stallreq_o(stallreq_o), .hilo_we_o(hilo_we_o),
    .hi_o(hi_o), .lo_o(lo_o), .divzero_o(divzero_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  task automatic test_reset();
    @(negedge clk); #1;
    total++; if ({div_start_o, div_annul_o, div_signed_o, stallreq_o, hilo_we_o, divzero_o, err_o} !== 7'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=0000000", {div_start_o, div_annul_o, div_signed_o, stallreq_o, hilo_we_o, divzero_o, err_o}); end
    total++; if ({div_op1_o, div_op2_o, hi_o, lo_o} !== 128'h0) begin
      bad++; $display("FAIL reset_data got=%h exp=0", {div_op1_o, div_op2_o, hi_o, lo_o}); end
    @(negedge clk); rst = 1'b1;
  endtask

  // DIVU 100/7 -> rem 2, quo 14; two plain BUSY cycles then ready
  task automatic test_divu();
    @(negedge clk); div_req_i = 1; div_signed_i = 0; reg1_i = 32'd100; reg2_i = 32'd7; #1;
    total++; if (stallreq_o !== 1'b1) begin bad++; $display("FAIL divu_req_stall got=%b exp=1", stallreq_o); end
    total++; if (div_start_o !== 1'b0) begin bad++; $display("FAIL divu_req_start got=%b exp=0", div_start_o); end
    @(negedge clk); div_req_i = 0; reg1_i = 32'hDEAD; reg2_i = 32'hBEEF; #1;
    total++; if (div_start_o !== 1'b1) begin bad++; $display("FAIL divu_busy_start got=%b exp=1", div_start_o); end
    total++; if ({div_op1_o, div_op2_o, div_signed_o} !== {32'd100, 32'd7, 1'b0}) begin
      bad++; $display("FAIL divu_ops got=%h/%h/%b exp=64/7/0", div_op1_o, div_op2_o, div_signed_o); end
    @(negedge clk); #1;
    total++; if (div_start_o !== 1'b1) begin bad++; $display("FAIL divu_busy2_start got=%b exp=1", div_start_o); end
    @(negedge clk); div_ready_i = 1; div_result_i = {32'd2, 32'd14}; #1;
    total++; if (hilo_we_o !== 1'b0) begin bad++; $display("FAIL divu_ready_we got=%b exp=0", hilo_we_o); end
    @(negedge clk); div_ready_i = 0; div_result_i = '0; #1;
    total++; if ({hilo_we_o, div_start_o, stallreq_o} !== 3'b100) begin
      bad++; $display("FAIL divu_done_ctrl got=%b exp=100", {hilo_we_o, div_start_o, stallreq_o}); end
    total++; if ({hi_o, lo_o} !== {32'h00000002, 32'h0000000E}) begin
      bad++; $display("FAIL divu_done_hilo got=%h exp=000000020000000e", {hi_o, lo_o}); end
    @(negedge clk); #1;
    total++; if (hilo_we_o !== 1'b0) begin bad++; $display("FAIL divu_idle_we got=%b exp=0", hilo_we_o); end
  endtask

  // DIV -7/2 -> rem -1, quo -3; stallreq spans req, BUSY1, BUSY2(ready)
  task automatic test_div_signed();
    int hi_cnt;
    hi_cnt = 0;
    @(negedge clk); div_req_i = 1; div_signed_i = 1; reg1_i = 32'hFFFFFFF9; reg2_i = 32'd2; #1;
    if (stallreq_o) hi_cnt++;
    @(negedge clk); div_req_i = 0; div_signed_i = 0; #1;
    if (stallreq_o) hi_cnt++;
    total++; if (div_signed_o !== 1'b1) begin bad++; $display("FAIL div_signed_flag got=%b exp=1", div_signed_o); end
    @(negedge clk); div_ready_i = 1; div_result_i = {32'hFFFFFFFF, 32'hFFFFFFFD}; #1;
    if (stallreq_o) hi_cnt++;
    @(negedge clk); div_ready_i = 0; div_result_i = '0; #1;
    total++; if (stallreq_o !== 1'b0) begin bad++; $display("FAIL div_done_stall got=%b exp=0", stallreq_o); end
    total++; if (hi_cnt !== 3) begin bad++; $display("FAIL div_stall_cycles got=%0d exp=3", hi_cnt); end
    total++; if ({hi_o, lo_o, hilo_we_o} !== {32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1}) begin
      bad++; $display("FAIL div_done_hilo got=%h/%h/%b exp=ffffffff/fffffffd/1", hi_o, lo_o, hilo_we_o); end
    @(negedge clk); #1;
  endtask

  // Flush on the fifth BUSY cycle, then a clean DIVU 20/3 -> rem 2, quo 6
  task automatic test_flush_busy();
    bit seen_we;
    seen_we = 0;
    @(negedge clk); div_req_i = 1; div_signed_i = 0; reg1_i = 32'd1000; reg2_i = 32'd10; #1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); div_req_i = 0; flush_i = (k == 5); #1;
      if (hilo_we_o) seen_we = 1;
      if (k < 5) begin
        total++; if (div_annul_o !== 1'b0) begin bad++; $display("FAIL flush_pre_annul k=%0d got=%b exp=0", k, div_annul_o); end
      end
    end
    total++; if (div_annul_o !== 1'b1) begin bad++; $display("FAIL flush_annul got=%b exp=1", div_annul_o); end
    @(negedge clk); flush_i = 0; #1;
    if (hilo_we_o) seen_we = 1;
    total++; if ({div_start_o, div_annul_o, stallreq_o} !== 3'b000) begin
      bad++; $display("FAIL flush_after got=%b exp=000", {div_start_o, div_annul_o, stallreq_o}); end
    @(negedge clk); #1;
    if (hilo_we_o) seen_we = 1;
    total++; if (seen_we !== 1'b0) begin bad++; $display("FAIL flush_hilo_we got=%b exp=0", seen_we); end
    div_req_i = 1; reg1_i = 32'd20; reg2_i = 32'd3;
    @(negedge clk); div_req_i = 0; div_ready_i = 1; div_result_i = {32'd2, 32'd6}; #1;
    total++; if (div_op1_o !== 32'd20) begin bad++; $display("FAIL flush_next_op1 got=%h exp=14", div_op1_o); end
    @(negedge clk); div_ready_i = 0; #1;
    total++; if ({hi_o, lo_o, hilo_we_o} !== {32'd2, 32'd6, 1'b1}) begin
      bad++; $display("FAIL flush_next_hilo got=%h/%h/%b exp=2/6/1", hi_o, lo_o, hilo_we_o); end
    @(negedge clk); #1;
  endtask

  // 50/8 -> rem 2, quo 6; stall keeps DONE for three cycles
  task automatic test_stall_done();
    @(negedge clk); div_req_i = 1; reg1_i = 32'd50; reg2_i = 32'd8; #1;
    @(negedge clk); div_req_i = 0; div_ready_i = 1; div_result_i = {32'd2, 32'd6}; stall_i = 1; #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); div_ready_i = 0; div_result_i = '0; stall_i = (i < 2); #1;
      total++; if ({hilo_we_o, div_start_o, hi_o, lo_o} !== {1'b1, 1'b0, 32'd2, 32'd6}) begin
        bad++; $display("FAIL stall_hold i=%0d got=%b/%b/%h/%h exp=1/0/2/6", i, hilo_we_o, div_start_o, hi_o, lo_o); end
    end
    @(negedge clk); #1;
    total++; if (hilo_we_o !== 1'b0) begin bad++; $display("FAIL stall_release_we got=%b exp=0", hilo_we_o); end
  endtask

  // Flush in DONE suppresses the write even though stall is high
  task automatic test_flush_done();
    @(negedge clk); div_req_i = 1; reg1_i = 32'd9; reg2_i = 32'd3; #1;
    @(negedge clk); div_req_i = 0; div_ready_i = 1; div_result_i = {32'd0, 32'd3}; #1;
    @(negedge clk); div_ready_i = 0; flush_i = 1; stall_i = 1; #1;
    total++; if (hilo_we_o !== 1'b0) begin bad++; $display("FAIL flushdone_we got=%b exp=0", hilo_we_o); end
    @(negedge clk); flush_i = 0; #1;
    total++; if (hilo_we_o !== 1'b0) begin bad++; $display("FAIL flushdone_idle_we got=%b exp=0", hilo_we_o); end
    stall_i = 0;
  endtask

  // Request held high: ignored in DONE, re-issued from IDLE with start low between
  task automatic test_back_to_back();
    @(negedge clk); div_req_i = 1; reg1_i = 32'd30; reg2_i = 32'd4; #1;
    @(negedge clk); div_ready_i = 1; div_result_i = {32'd2, 32'd7}; #1;
    @(negedge clk); div_ready_i = 0; #1;
    total++; if ({stallreq_o, div_start_o, hilo_we_o} !== 3'b001) begin
      bad++; $display("FAIL b2b_done got=%b exp=001", {stallreq_o, div_start_o, hilo_we_o}); end
    @(negedge clk); #1;
    total++; if ({stallreq_o, div_start_o, hilo_we_o} !== 3'b100) begin
      bad++; $display("FAIL b2b_idle got=%b exp=100", {stallreq_o, div_start_o, hilo_we_o}); end
    @(negedge clk); div_req_i = 0; #1;
    total++; if (div_start_o !== 1'b1) begin bad++; $display("FAIL b2b_restart got=%b exp=1", div_start_o); end
    div_ready_i = 1;
    @(negedge clk); div_ready_i = 0; #1;
    @(negedge clk); #1;
  endtask

  // Divider never answers: abort on BUSY cycle MAX_CYC
  task automatic test_watchdog();
    @(negedge clk); div_req_i = 1; reg1_i = 32'd77; reg2_i = 32'd5; #1;
    for (int k = 1; k <= MAX_CYC; k++) begin
      @(negedge clk); div_req_i = 0; #1;
      total++; if ({err_o, div_annul_o} !== {2{k == MAX_CYC}}) begin
        bad++; $display("FAIL wdog k=%0d got=%b exp=%b", k, {err_o, div_annul_o}, {2{k == MAX_CYC}}); end
    end
    @(negedge clk); #1;
    total++; if ({div_start_o, err_o, stallreq_o, hi_o, lo_o} !== 67'h0) begin
      bad++; $display("FAIL wdog_after got=%b/%b/%b/%h/%h exp=0", div_start_o, err_o, stallreq_o, hi_o, lo_o); end
  endtask

  task automatic test_reset_busy();
    @(negedge clk); div_req_i = 1; div_signed_i = 1; reg1_i = 32'd9; reg2_i = 32'd4; #1;
    @(negedge clk); div_req_i = 0; div_signed_i = 0; div_ready_i = 1; div_result_i = {32'd1, 32'd2}; #1;
    @(negedge clk); div_ready_i = 0; stall_i = 1; #1;
    @(negedge clk); stall_i = 0; #1;
    @(negedge clk); div_req_i = 1; div_signed_i = 1; reg1_i = 32'd9; reg2_i = 32'd4; #1;
    @(negedge clk); div_req_i = 0; div_signed_i = 0; #1;
    total++; if (div_start_o !== 1'b1) begin bad++; $display("FAIL rstbusy_pre got=%b exp=1", div_start_o); end
    @(negedge clk); rst = 1'b0; #1;
    total++; if ({div_start_o, div_annul_o, div_signed_o, stallreq_o, hilo_we_o, divzero_o, err_o} !== 7'b0) begin
      bad++; $display("FAIL rstbusy_ctrl got=%b exp=0000000", {div_start_o, div_annul_o, div_signed_o, stallreq_o, hilo_we_o, divzero_o, err_o}); end
    total++; if ({div_op1_o, div_op2_o, hi_o, lo_o} !== 128'h0) begin
      bad++; $display("FAIL rstbusy_data got=%h exp=0", {div_op1_o, div_op2_o, hi_o, lo_o}); end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_div_zero();
    @(negedge clk); div_req_i = 1; div_signed_i = 1; reg1_i = 32'd8; reg2_i = 32'd0; #1;
    total++; if (stallreq_o !== 1'b1) begin bad++; $display("FAIL dz_req_stall got=%b exp=1", stallreq_o); end
`ifdef DIV_ZERO_FLAG_EN
    @(negedge clk); div_req_i = 0; #1;
    total++; if ({div_start_o, divzero_o, hilo_we_o, stallreq_o} !== 4'b0110) begin
      bad++; $display("FAIL dz_done got=%b exp=0110", {div_start_o, divzero_o, hilo_we_o, stallreq_o}); end
    total++; if ({hi_o, lo_o} !== 64'h0) begin bad++; $display("FAIL dz_hilo got=%h exp=0", {hi_o, lo_o}); end
    @(negedge clk); #1;
    total++; if ({divzero_o, hilo_we_o, div_start_o} !== 3'b000) begin
      bad++; $display("FAIL dz_idle got=%b exp=000", {divzero_o, hilo_we_o, div_start_o}); end
`else
    @(negedge clk); div_req_i = 0; #1;
    total++; if ({div_start_o, div_op2_o, divzero_o} !== {1'b1, 32'd0, 1'b0}) begin
      bad++; $display("FAIL dz_issue got=%b/%h/%b exp=1/0/0", div_start_o, div_op2_o, divzero_o); end
    div_ready_i = 1; div_result_i = '0;
    @(negedge clk); div_ready_i = 0; #1;
    total++; if ({hilo_we_o, divzero_o, div_start_o} !== 3'b100) begin
      bad++; $display("FAIL dz_done got=%b exp=100", {hilo_we_o, divzero_o, div_start_o}); end
    @(negedge clk); #1;
`endif
    div_signed_i = 0;
  endtask

  initial begin
    test_reset();
    test_divu();
    test_div_signed();
    test_flush_busy();
    test_stall_done();
    test_flush_done();
    test_back_to_back();
    test_watchdog();
    test_reset_busy();
    test_div_zero();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
